sp_memory_axi_bist: RTL
=======================

# sp_memory_axi_bist

Built-in self-test master for the AXI4-Lite single-port memory slave. It sits directly upstream of that slave and drives its AXI4-Lite slave port. On start it writes a selected data pattern to every word, reads every word back, and compares each word against the expected value. It reports pass/fail, a saturating error count, and the first failing address and data to software or a test controller.

## Interface
- WIDTH, 32: data width in bits; multiple of 8, 8..64.
- DEPTH, 1024: number of words tested; power of two, ≥2.
- BASE_ADDR, 32'h0: byte address of word 0.

Clock and reset: aresetn, asynchronous, active-low; clock aclk.
- aclk  in  1  clock
- aresetn  in  1  async active-low reset
- start  in  1  single-cycle pulse; ignored while busy
- abort  in  1  pulse; terminate the test early
- mode  in  2  pattern select, sampled at start
- busy  out  1  test in progress
- done  out  1  high from test end until next accepted start
- pass  out  1  done && err_count==0 && !aborted
- err_count  out  16  mismatches plus bad responses; saturates at 16'hFFFF
- first_err_addr  out  32  byte address of first error
- first_err_data  out  WIDTH  rdata of first error (0 if the error was a bresp)
- AXI4-Lite master: awaddr[31:0], awprot[2:0], awvalid out, awready in; wdata[WIDTH-1:0], wstrb[WIDTH/8-1:0], wvalid out, wready in; bresp[1:0], bvalid in, bready out; araddr[31:0], arprot[2:0], arvalid out, arready in; rdata[WIDTH-1:0], rresp[1:0], rvalid in, rready out

## Operation
- Word index i = 0..DEPTH-1. Address = BASE_ADDR + i*(WIDTH/8), 32-bit wrap.
- Pattern, set by mode:
  - 0: i zero-extended
  - 1: 0x55.. for even i, 0xAA.. for odd i
  - 2: ~i (WIDTH bits)
  - 3: all ones
- wstrb is all ones. awprot and arprot are 0.
- FSM states: IDLE → WR_REQ → WR_RESP → (next i) … → RD_REQ → RD_RESP → (next i) … → FIN → IDLE.
- On accepted start:
  - clear err_count, first_err_*, done, and aborted
  - latch mode; i=0
  - go to WR_REQ
- WR_REQ:
  - awvalid and wvalid are both asserted.
  - Each is dropped independently after its own handshake.
  - Leave WR_REQ when both handshakes are done.
- WR_RESP: bready=1. On the bvalid handshake, a bresp≠0 counts as an error (first_err_data=0). If i=DEPTH-1, set i=0 and go to RD_REQ; otherwise increment i and return to WR_REQ.
- RD_REQ: arvalid=1 until the arready handshake.
- RD_RESP: rready=1. On the rvalid handshake, an error is rresp≠0 or rdata≠expected. If i=DEPTH-1 go to FIN; otherwise increment i and return to RD_REQ.
- Each error increments err_count (saturating). The first error latches first_err_addr and first_err_data.
- FIN: set done for one cycle, then go to IDLE. done then holds until the next start.
- abort:
  - Latch a sticky abort request.
  - Valid signals already asserted stay asserted until handshake, and an outstanding response is still collected.
  - The FSM then goes to FIN with aborted=1, so pass=0.
- abort in IDLE is ignored.

## Timing
- Reset values: all valid and ready outputs 0; busy, done, pass 0; err_count, first_err_* 0; addresses and data 0; FSM IDLE.
- All outputs are registered.
- awvalid, wvalid, and arvalid rise in the cycle after the state is entered.
- Valid signals never deassert before handshake.
- A valid signal's address and data are stable while it is asserted.
- One transaction is outstanding at a time; write and read phases never overlap.
- start to first awvalid: 1 cycle. busy rises the cycle after start.
- done and busy update in the same cycle; busy falls as done rises.
- bvalid or rvalid arriving in the same cycle as the request handshake is accepted on the next cycle; bready and rready are driven from state.
- An aresetn assertion mid-test returns to reset values immediately. No AXI completion is attempted.

## Structure
- Package sp_memory_axi_bist_pkg holds:
  - state_t enum {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, FIN}
  - mode constants PAT_ADDR, PAT_CHECKER, PAT_NADDR, PAT_ONES
  - AXI_RESP_OKAY = 2'b00
- Sub-module sp_memory_axi_bist_pattern: combinational; (mode, i) → expected word. It is shared by the write path and the compare path.

## Test plan
- With sp_memory_axi, DEPTH=16, mode=0, start → 16 writes then 16 reads. done=1, pass=1, err_count=0; word 5 holds 32'h5.
- mode=1, then mode=2, against sp_memory_axi → pass=1. Readback of word 3 = 32'hAAAAAAAA (mode 1) and 32'hFFFFFFFC (mode 2).
- Behavioural slave corrupts the read of word 7 (XOR 1) and word 9 → err_count=2, first_err_addr=BASE_ADDR+28, first_err_data=expected^1, pass=0.
- Slave returns bresp=2'b10 on word 0 and holds awready/wready low for 0–5 random cycles each. Required: valid/data stable until handshake, err_count=1, first_err_addr=BASE_ADDR.
- abort pulsed while awvalid is high and awready is stalled 3 cycles → AW/W complete, B is collected, then done=1, pass=0, busy=0, and no further transactions.
- aresetn pulsed during RD_RESP → all outputs at reset values next cycle. A new start runs a full test to pass=1.

Source files
------------

// File: rtl/sp_memory_axi_bist_pkg.sv
// Shared types and constants for the single-port memory AXI4-Lite BIST master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sp_memory_axi_bist_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        FIN     = 3'd5
    } state_t;

    localparam logic [1:0] PAT_ADDR    = 2'd0;
    localparam logic [1:0] PAT_CHECKER = 2'd1;
    localparam logic [1:0] PAT_NADDR   = 2'd2;
    localparam logic [1:0] PAT_ONES    = 2'd3;

    localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;
    localparam logic [15:0] ERR_MAX       = 16'hFFFF;

    // Error counter increment that sticks at its maximum.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == ERR_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sp_memory_axi_bist_pattern.sv
// Expected test word for a given pattern mode and word index.
// Latency: purely combinational.
// Backpressure: none.
module sp_memory_axi_bist_pattern
    import sp_memory_axi_bist_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IW    = 10
) (
    input  logic [1:0]       mode,
    input  logic [IW-1:0]    idx,
    output logic [WIDTH-1:0] word
);

    // Select the pattern; the checkerboard alternates on the index LSB.
    always_comb begin
        word = '1;
        case (mode)
            PAT_ADDR:    word = WIDTH'(idx);
            PAT_CHECKER: word = idx[0] ? {(WIDTH/8){8'hAA}} : {(WIDTH/8){8'h55}};
            PAT_NADDR:   word = ~WIDTH'(idx);
            default:     word = '1;
        endcase
    end

endmodule

// File: rtl/sp_memory_axi_bist.sv
// Memory BIST master: writes a pattern to every word over AXI4-Lite, reads back, compares.
// Latency: start to first awvalid 1 cycle; one transaction outstanding at a time.
// Backpressure: valids hold (address/data stable) until handshake; abort drains the open transaction.
module sp_memory_axi_bist
    import sp_memory_axi_bist_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         mode,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [15:0]        err_count,
    output logic [31:0]        first_err_addr,
    output logic [WIDTH-1:0]   first_err_data,
    output logic [31:0]        awaddr,
    output logic [2:0]         awprot,
    output logic               awvalid,
    input  logic               awready,
    output logic [WIDTH-1:0]   wdata,
    output logic [WIDTH/8-1:0] wstrb,
    output logic               wvalid,
    input  logic               wready,
    input  logic [1:0]         bresp,
    input  logic               bvalid,
    output logic               bready,
    output logic [31:0]        araddr,
    output logic [2:0]         arprot,
    output logic               arvalid,
    input  logic               arready,
    input  logic [WIDTH-1:0]   rdata,
    input  logic [1:0]         rresp,
    input  logic               rvalid,
    output logic               rready
);

    localparam int          IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] BYTES = 32'(WIDTH / 8);
    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

    function automatic logic [31:0] addr_of(input logic [IW-1:0] i);
        return BASE_ADDR + (32'(i) * BYTES);
    endfunction

    state_t            state, state_nxt;
    logic [IW-1:0]     idx, idx_nxt;
    logic [1:0]        mode_q, mode_nxt;
    logic              abort_req, abort_req_nxt, abort_pend;
    logic              aborted, aborted_nxt;
    logic              busy_nxt, done_nxt, pass_nxt;
    logic [15:0]       err_count_nxt;
    logic [31:0]       first_err_addr_nxt;
    logic [WIDTH-1:0]  first_err_data_nxt;
    logic              awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt;
    logic [31:0]       awaddr_nxt, araddr_nxt;
    logic [WIDTH-1:0]  wdata_nxt;
    logic              err_hit, finish;
    logic [31:0]       err_addr;
    logic [WIDTH-1:0]  err_data;
    logic [IW-1:0]     pat_idx;
    logic [1:0]        pat_mode;
    logic [WIDTH-1:0]  exp_word;

    assign awprot = 3'b000;
    assign arprot = 3'b000;
    assign wstrb  = '1;

    // One pattern generator: it supplies the next write word, or the word being compared in RD_RESP.
    assign pat_idx  = (state == RD_RESP) ? idx : ((state == IDLE) ? '0 : idx + IW'(1));
    assign pat_mode = (state == IDLE) ? mode : mode_q;

    sp_memory_axi_bist_pattern #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_pattern (
        .mode (pat_mode),
        .idx  (pat_idx),
        .word (exp_word)
    );

    // Next-state and next registered-output logic.
    always_comb begin
        state_nxt          = state;
        idx_nxt            = idx;
        mode_nxt           = mode_q;
        abort_req_nxt      = abort_req;
        aborted_nxt        = aborted;
        busy_nxt           = busy;
        done_nxt           = done;
        err_count_nxt      = err_count;
        first_err_addr_nxt = first_err_addr;
        first_err_data_nxt = first_err_data;
        awvalid_nxt        = awvalid;
        awaddr_nxt         = awaddr;
        wvalid_nxt         = wvalid;
        wdata_nxt          = wdata;
        bready_nxt         = bready;
        arvalid_nxt        = arvalid;
        araddr_nxt         = araddr;
        rready_nxt         = rready;
        err_hit            = 1'b0;
        err_addr           = '0;
        err_data           = '0;
        finish             = 1'b0;
        abort_pend         = abort_req || abort;

        // Abort is only meaningful while a test is running.
        if (abort && state != IDLE && state != FIN) begin
            abort_req_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                if (start) begin
                    err_count_nxt      = '0;
                    first_err_addr_nxt = '0;
                    first_err_data_nxt = '0;
                    done_nxt           = 1'b0;
                    aborted_nxt        = 1'b0;
                    abort_req_nxt      = 1'b0;
                    mode_nxt           = mode;
                    idx_nxt            = '0;
                    busy_nxt           = 1'b1;
                    awvalid_nxt        = 1'b1;
                    wvalid_nxt         = 1'b1;
                    awaddr_nxt         = addr_of('0);
                    wdata_nxt          = exp_word;
                    state_nxt          = WR_REQ;
                end
            end
            WR_REQ: begin
                if (awvalid && awready) awvalid_nxt = 1'b0;
                if (wvalid && wready)   wvalid_nxt  = 1'b0;
                if ((!awvalid || awready) && (!wvalid || wready)) begin
                    bready_nxt = 1'b1;
                    state_nxt  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bvalid) begin
                    bready_nxt = 1'b0;
                    if (bresp != AXI_RESP_OKAY) begin
                        err_hit  = 1'b1;
                        err_addr = awaddr;
                    end
                    if (abort_pend) begin
                        finish = 1'b1;
                    end else if (idx == LAST) begin
                        idx_nxt     = '0;
                        arvalid_nxt = 1'b1;
                        araddr_nxt  = addr_of('0);
                        state_nxt   = RD_REQ;
                    end else begin
                        idx_nxt     = idx + IW'(1);
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                        awaddr_nxt  = addr_of(idx + IW'(1));
                        wdata_nxt   = exp_word;
                        state_nxt   = WR_REQ;
                    end
                end
            end
            RD_REQ: begin
                if (arready) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    state_nxt   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (rvalid) begin
                    rready_nxt = 1'b0;
                    if (rresp != AXI_RESP_OKAY || rdata != exp_word) begin
                        err_hit  = 1'b1;
                        err_addr = araddr;
                        err_data = rdata;
                    end
                    if (abort_pend || idx == LAST) begin
                        finish = 1'b1;
                    end else begin
                        idx_nxt     = idx + IW'(1);
                        arvalid_nxt = 1'b1;
                        araddr_nxt  = addr_of(idx + IW'(1));
                        state_nxt   = RD_REQ;
                    end
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (finish) begin
            state_nxt     = FIN;
            busy_nxt      = 1'b0;
            done_nxt      = 1'b1;
            aborted_nxt   = abort_pend;
            abort_req_nxt = 1'b0;
        end

        if (err_hit) begin
            if (err_count == '0) begin
                first_err_addr_nxt = err_addr;
                first_err_data_nxt = err_data;
            end
            err_count_nxt = sat_inc(err_count);
        end

        pass_nxt = done_nxt && (err_count_nxt == '0) && !aborted_nxt;
    end

    // FSM state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered datapath, status and AXI outputs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            idx            <= '0;
            mode_q         <= '0;
            abort_req      <= 1'b0;
            aborted        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            awvalid        <= 1'b0;
            awaddr         <= '0;
            wvalid         <= 1'b0;
            wdata          <= '0;
            bready         <= 1'b0;
            arvalid        <= 1'b0;
            araddr         <= '0;
            rready         <= 1'b0;
        end else begin
            idx            <= idx_nxt;
            mode_q         <= mode_nxt;
            abort_req      <= abort_req_nxt;
            aborted        <= aborted_nxt;
            busy           <= busy_nxt;
            done           <= done_nxt;
            pass           <= pass_nxt;
            err_count      <= err_count_nxt;
            first_err_addr <= first_err_addr_nxt;
            first_err_data <= first_err_data_nxt;
            awvalid        <= awvalid_nxt;
            awaddr         <= awaddr_nxt;
            wvalid         <= wvalid_nxt;
            wdata          <= wdata_nxt;
            bready         <= bready_nxt;
            arvalid        <= arvalid_nxt;
            araddr         <= araddr_nxt;
            rready         <= rready_nxt;
        end
    end

endmodule
